// File: rtl/msp430_pkg.sv
// msp430_pkg: shared constants for the MSP430x2xx double-operand controller.
//   - opcode constants for format I instructions (MOV..AND)
//   - source addressing-mode constants (As field)
//   - one-hot controller state encoding
//   - register index of the program counter
package msp430_pkg;

  localparam logic [3:0] OP_MOV  = 4'h4;
  localparam logic [3:0] OP_ADD  = 4'h5;
  localparam logic [3:0] OP_ADDC = 4'h6;
  localparam logic [3:0] OP_SUBC = 4'h7;
  localparam logic [3:0] OP_SUB  = 4'h8;
  localparam logic [3:0] OP_CMP  = 4'h9;
  localparam logic [3:0] OP_DADD = 4'hA;
  localparam logic [3:0] OP_BIT  = 4'hB;
  localparam logic [3:0] OP_BIC  = 4'hC;
  localparam logic [3:0] OP_BIS  = 4'hD;
  localparam logic [3:0] OP_XOR  = 4'hE;
  localparam logic [3:0] OP_AND  = 4'hF;

  localparam logic [1:0] AS_REG = 2'b00;
  localparam logic [1:0] AS_IMM = 2'b11;

  localparam logic [3:0] R_PC = 4'h0;

  typedef enum logic [4:0] {
    ST_FETCH  = 5'b00001,
    ST_DECODE = 5'b00010,
    ST_IMM    = 5'b00100,
    ST_EXEC   = 5'b01000,
    ST_WB     = 5'b10000
  } state_t;

endpackage

// File: rtl/double_op_decode.sv
// double_op_decode: combinational classification of a format I instruction word.
// Ports:
//   i_instr        in  16  latched instruction register
//   o_is_illegal   out 1   encoding not supported by this controller
//   o_is_imm       out 1   source is @PC+ (immediate extension word follows)
//   o_writes_dst   out 1   result is written back (all but CMP and BIT)
//   o_writes_flags out 1   SR flags updated (all but MOV, BIC and BIS)
module double_op_decode
  import msp430_pkg::*;
(
  input  logic [15:0] i_instr,
  output logic        o_is_illegal,
  output logic        o_is_imm,
  output logic        o_writes_dst,
  output logic        o_writes_flags
);

  logic [3:0] w_opcode;
  logic [3:0] w_src;
  logic       w_ad;
  logic [1:0] w_as;
  logic       w_unused;

  assign w_opcode = i_instr[15:12];
  assign w_src    = i_instr[11:8];
  assign w_ad     = i_instr[7];
  assign w_as     = i_instr[5:4];
  // Byte flag and destination field do not affect classification.
  assign w_unused = ^{i_instr[6], i_instr[3:0]};

  // Encoding legality and immediate detection.
  always_comb begin
    o_is_illegal = 1'b0;
    o_is_imm     = 1'b0;
    if (w_opcode < OP_MOV) begin
      o_is_illegal = 1'b1;
    end else if (w_ad) begin
      o_is_illegal = 1'b1;
    end else begin
      case (w_as)
        AS_REG: begin
          o_is_illegal = 1'b0;
        end
        AS_IMM: begin
          // Only @R0+ (immediate) is supported among the autoincrement modes.
          if (w_src == R_PC) begin
            o_is_imm = 1'b1;
          end else begin
            o_is_illegal = 1'b1;
          end
        end
        default: begin
          o_is_illegal = 1'b1;
        end
      endcase
    end
  end

  // Write-back and flag-update classes per opcode.
  always_comb begin
    o_writes_dst   = 1'b1;
    o_writes_flags = 1'b1;
    case (w_opcode)
      OP_CMP, OP_BIT:         o_writes_dst   = 1'b0;
      OP_MOV, OP_BIC, OP_BIS: o_writes_flags = 1'b0;
      default: begin
        o_writes_dst   = 1'b1;
        o_writes_flags = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/double_op_ctrl.sv
// double_op_ctrl: one-hot sequencer for MSP430 double-operand instructions.
// Ports:
//   Clk, Rst      clock and synchronous active-high reset
//   Load_en       run enable, sampled only in FETCH
//   Mem_data      program-memory word at the current PC
//   Instr         instruction register
//   Fsm           one-hot state (FETCH, DECODE, IMM, EXEC, WB)
//   PC_inc        PC increment strobe (FETCH with Load_en, IMM)
//   Imm_ld        latch Mem_data as immediate source (IMM)
//   Src_sel_imm   ALU A from immediate latch (EXEC/WB of immediate ops)
//   Src_reg       Instr[11:8]; Dst_reg Instr[3:0]; Alu_op Instr[15:12]; Byte_op Instr[6]
//   Flags_ld      SR update strobe (EXEC)
//   Wr_en         register write strobe (WB)
//   Illegal       one-cycle pulse in DECODE on unsupported encoding
//   Retired       wrapping count of completed instructions
module double_op_ctrl
  import msp430_pkg::*;
#(
  parameter int STATE_W = 5,
  parameter int CNT_W   = 16
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Load_en,
  input  logic [15:0]        Mem_data,
  output logic [15:0]        Instr,
  output logic [STATE_W-1:0] Fsm,
  output logic               PC_inc,
  output logic               Imm_ld,
  output logic               Src_sel_imm,
  output logic [3:0]         Src_reg,
  output logic [3:0]         Dst_reg,
  output logic [3:0]         Alu_op,
  output logic               Byte_op,
  output logic               Flags_ld,
  output logic               Wr_en,
  output logic               Illegal,
  output logic [CNT_W-1:0]   Retired
);

  state_t             r_state;
  state_t             w_next;
  logic [15:0]        r_instr;
  logic [CNT_W-1:0]   r_retired;
  logic               w_is_illegal;
  logic               w_is_imm;
  logic               w_writes_dst;
  logic               w_writes_flags;
  logic               w_retire;

  double_op_decode u_decode (
    .i_instr        (r_instr),
    .o_is_illegal   (w_is_illegal),
    .o_is_imm       (w_is_imm),
    .o_writes_dst   (w_writes_dst),
    .o_writes_flags (w_writes_flags)
  );

  // Next-state selection.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_FETCH: begin
        if (Load_en) w_next = ST_DECODE;
        else         w_next = ST_FETCH;
      end
      ST_DECODE: begin
        if (w_is_illegal)  w_next = ST_FETCH;
        else if (w_is_imm) w_next = ST_IMM;
        else               w_next = ST_EXEC;
      end
      ST_IMM:  w_next = ST_EXEC;
      ST_EXEC: begin
        if (w_writes_dst) w_next = ST_WB;
        else              w_next = ST_FETCH;
      end
      ST_WB:   w_next = ST_FETCH;
      default: w_next = ST_FETCH;
    endcase
  end

  // An instruction completes leaving EXEC (no write-back) or leaving WB.
  assign w_retire = ((r_state == ST_EXEC) && !w_writes_dst) || (r_state == ST_WB);

  // State, instruction register and retirement counter.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state   <= ST_FETCH;
      r_instr   <= 16'h0000;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == ST_FETCH) && Load_en) begin
        r_instr <= Mem_data;
      end
      if (w_retire) begin
        r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

  // Strobes decode directly from the state register; PC_inc in FETCH also
  // needs Load_en so a stalled fetch never advances the PC.
  assign PC_inc      = ((r_state == ST_FETCH) && Load_en) || (r_state == ST_IMM);
  assign Imm_ld      = (r_state == ST_IMM);
  assign Src_sel_imm = w_is_imm && ((r_state == ST_EXEC) || (r_state == ST_WB));
  assign Flags_ld    = (r_state == ST_EXEC) && w_writes_flags;
  assign Wr_en       = (r_state == ST_WB);
  assign Illegal     = (r_state == ST_DECODE) && w_is_illegal;

  assign Instr   = r_instr;
  assign Fsm     = STATE_W'(r_state);
  assign Src_reg = r_instr[11:8];
  assign Dst_reg = r_instr[3:0];
  assign Alu_op  = r_instr[15:12];
  assign Byte_op = r_instr[6];
  assign Retired = r_retired;

endmodule

// File: tb/tb_double_op_ctrl.sv
// Directed testbench for double_op_ctrl. A second instance with a 4-bit
// counter exercises the retirement-counter wrap in a short run.
module tb_double_op_ctrl;

  logic        Clk = 1'b0;
  logic        Rst, Load_en;
  logic [15:0] Mem_data, Instr;
  logic [4:0]  Fsm;
  logic        PC_inc, Imm_ld, Src_sel_imm, Byte_op, Flags_ld, Wr_en, Illegal;
  logic [3:0]  Src_reg, Dst_reg, Alu_op;
  logic [15:0] Retired;

  logic        rst2, load_en2;
  logic [15:0] mem_data2, instr2;
  logic [4:0]  fsm2;
  logic        pc_inc2, imm_ld2, src_sel_imm2, byte_op2, flags_ld2, wr_en2, illegal2;
  logic [3:0]  src_reg2, dst_reg2, alu_op2;
  logic [3:0]  retired2;

  int checks = 0;
  int errors = 0;
  int n_pc, n_wr, n_fl, n_il, n_imm;
  logic [15:0] exp_ret;
  logic [15:0] exp_instr;

  always #5 Clk = ~Clk;

  double_op_ctrl #(.STATE_W(5), .CNT_W(16)) dut (
    .Clk(Clk), .Rst(Rst), .Load_en(Load_en), .Mem_data(Mem_data),
    .Instr(Instr), .Fsm(Fsm), .PC_inc(PC_inc), .Imm_ld(Imm_ld),
    .Src_sel_imm(Src_sel_imm), .Src_reg(Src_reg), .Dst_reg(Dst_reg),
    .Alu_op(Alu_op), .Byte_op(Byte_op), .Flags_ld(Flags_ld), .Wr_en(Wr_en),
    .Illegal(Illegal), .Retired(Retired)
  );

  double_op_ctrl #(.STATE_W(5), .CNT_W(4)) dut_wrap (
    .Clk(Clk), .Rst(rst2), .Load_en(load_en2), .Mem_data(mem_data2),
    .Instr(instr2), .Fsm(fsm2), .PC_inc(pc_inc2), .Imm_ld(imm_ld2),
    .Src_sel_imm(src_sel_imm2), .Src_reg(src_reg2), .Dst_reg(dst_reg2),
    .Alu_op(alu_op2), .Byte_op(byte_op2), .Flags_ld(flags_ld2), .Wr_en(wr_en2),
    .Illegal(illegal2), .Retired(retired2)
  );

  task automatic clr_cnt();
    n_pc = 0; n_wr = 0; n_fl = 0; n_il = 0; n_imm = 0;
  endtask

  // Accumulate strobes of the current cycle, then advance one clock.
  task automatic tick();
    if (PC_inc)   n_pc++;
    if (Wr_en)    n_wr++;
    if (Flags_ld) n_fl++;
    if (Illegal)  n_il++;
    if (Imm_ld)   n_imm++;
    @(posedge Clk); #1;
  endtask

  task automatic do_reset();
    Rst = 1'b1; Load_en = 1'b0; Mem_data = 16'h0000;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    Rst = 1'b0;
    exp_ret = 16'h0000;
    exp_instr = 16'h0000;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (Fsm !== 5'b00001) begin errors++; $display("FAIL reset_fsm got %b exp 00001", Fsm); end
    checks++;
    if (Instr !== 16'h0000 || Retired !== 16'h0000) begin
      errors++; $display("FAIL reset_regs instr %h retired %h exp 0000 0000", Instr, Retired);
    end
    checks++;
    if ({PC_inc, Imm_ld, Src_sel_imm, Flags_ld, Wr_en, Illegal} !== 6'b000000) begin
      errors++; $display("FAIL reset_strobes got %b exp 000000",
                         {PC_inc, Imm_ld, Src_sel_imm, Flags_ld, Wr_en, Illegal});
    end
    checks++;
    if ({Src_reg, Dst_reg, Alu_op, Byte_op} !== 13'h0000) begin
      errors++; $display("FAIL reset_fields got %h exp 0", {Src_reg, Dst_reg, Alu_op, Byte_op});
    end
  endtask

  task automatic test_reg_add();
    logic [4:0] exp_fsm [0:4];
    exp_fsm = '{5'b00001, 5'b00010, 5'b01000, 5'b10000, 5'b00001};
    clr_cnt();
    for (int i = 0; i < 5; i++) begin
      Load_en = (i == 0); Mem_data = 16'h5405;
      #1;
      checks++;
      if (Fsm !== exp_fsm[i]) begin errors++; $display("FAIL add_fsm cyc %0d got %b exp %b", i, Fsm, exp_fsm[i]); end
      if (i == 2) begin
        checks++;
        if (Flags_ld !== 1'b1 || Alu_op !== 4'h5 || Wr_en !== 1'b0) begin
          errors++; $display("FAIL add_exec flags %b aluop %h wr %b exp 1 5 0", Flags_ld, Alu_op, Wr_en);
        end
      end
      if (i == 3) begin
        checks++;
        if (Wr_en !== 1'b1 || Dst_reg !== 4'd5 || Src_reg !== 4'd4 || PC_inc !== 1'b0 || Flags_ld !== 1'b0) begin
          errors++; $display("FAIL add_wb wr %b dst %0d src %0d pc %b fl %b exp 1 5 4 0 0",
                             Wr_en, Dst_reg, Src_reg, PC_inc, Flags_ld);
        end
      end
      if (i < 4) tick();
    end
    exp_ret = exp_ret + 16'd1;
    exp_instr = 16'h5405;
    checks++;
    if (Retired !== exp_ret) begin errors++; $display("FAIL add_retired got %0d exp %0d", Retired, exp_ret); end
    checks++;
    if (n_pc !== 1 || n_wr !== 1 || n_fl !== 1) begin
      errors++; $display("FAIL add_strobe_counts pc %0d wr %0d fl %0d exp 1 1 1", n_pc, n_wr, n_fl);
    end
  endtask

  task automatic test_imm_mov();
    logic [4:0] exp_fsm [0:5];
    exp_fsm = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
    clr_cnt();
    for (int i = 0; i < 6; i++) begin
      Load_en = (i == 0);
      Mem_data = (i == 0) ? 16'h4036 : 16'h1234;
      #1;
      checks++;
      if (Fsm !== exp_fsm[i]) begin errors++; $display("FAIL mov_fsm cyc %0d got %b exp %b", i, Fsm, exp_fsm[i]); end
      if (i == 2) begin
        checks++;
        if (Imm_ld !== 1'b1 || PC_inc !== 1'b1) begin
          errors++; $display("FAIL mov_imm imm_ld %b pc_inc %b exp 1 1", Imm_ld, PC_inc);
        end
      end
      if (i == 3) begin
        checks++;
        if (Src_sel_imm !== 1'b1 || Flags_ld !== 1'b0) begin
          errors++; $display("FAIL mov_exec sel_imm %b flags %b exp 1 0", Src_sel_imm, Flags_ld);
        end
      end
      if (i == 4) begin
        checks++;
        if (Wr_en !== 1'b1 || Dst_reg !== 4'd6 || Src_sel_imm !== 1'b1) begin
          errors++; $display("FAIL mov_wb wr %b dst %0d sel_imm %b exp 1 6 1", Wr_en, Dst_reg, Src_sel_imm);
        end
      end
      if (i == 5) begin
        checks++;
        if (Src_sel_imm !== 1'b0 || Instr !== 16'h4036) begin
          errors++; $display("FAIL mov_after sel_imm %b instr %h exp 0 4036", Src_sel_imm, Instr);
        end
      end
      if (i < 5) tick();
    end
    exp_ret = exp_ret + 16'd1;
    exp_instr = 16'h4036;
    checks++;
    if (Retired !== exp_ret) begin errors++; $display("FAIL mov_retired got %0d exp %0d", Retired, exp_ret); end
    checks++;
    if (n_pc !== 2 || n_imm !== 1 || n_fl !== 0 || n_wr !== 1) begin
      errors++; $display("FAIL mov_strobe_counts pc %0d imm %0d fl %0d wr %0d exp 2 1 0 1", n_pc, n_imm, n_fl, n_wr);
    end
  endtask

  task automatic test_reg_cmp();
    logic [4:0] exp_fsm [0:3];
    exp_fsm = '{5'b00001, 5'b00010, 5'b01000, 5'b00001};
    clr_cnt();
    for (int i = 0; i < 4; i++) begin
      Load_en = (i == 0); Mem_data = 16'h9405;
      #1;
      checks++;
      if (Fsm !== exp_fsm[i]) begin errors++; $display("FAIL cmp_fsm cyc %0d got %b exp %b", i, Fsm, exp_fsm[i]); end
      if (i == 2) begin
        checks++;
        if (Flags_ld !== 1'b1 || Wr_en !== 1'b0) begin
          errors++; $display("FAIL cmp_exec flags %b wr %b exp 1 0", Flags_ld, Wr_en);
        end
      end
      if (i < 3) tick();
    end
    exp_ret = exp_ret + 16'd1;
    exp_instr = 16'h9405;
    checks++;
    if (Retired !== exp_ret || n_wr !== 0 || n_pc !== 1) begin
      errors++; $display("FAIL cmp_totals retired %0d wr %0d pc %0d exp %0d 0 1", Retired, n_wr, n_pc, exp_ret);
    end
  endtask

  task automatic test_illegal();
    logic [15:0] words [0:4];
    logic [4:0]  exp_fsm [0:2];
    words   = '{16'h1004, 16'h5415, 16'h5485, 16'h5735, 16'h3405};
    exp_fsm = '{5'b00001, 5'b00010, 5'b00001};
    for (int w = 0; w < 5; w++) begin
      clr_cnt();
      for (int i = 0; i < 3; i++) begin
        Load_en = (i == 0); Mem_data = words[w];
        #1;
        checks++;
        if (Fsm !== exp_fsm[i]) begin
          errors++; $display("FAIL ill_fsm %h cyc %0d got %b exp %b", words[w], i, Fsm, exp_fsm[i]);
        end
        if (i == 1) begin
          checks++;
          if (Illegal !== 1'b1) begin errors++; $display("FAIL ill_pulse %h got %b exp 1", words[w], Illegal); end
        end
        if (i < 2) tick();
      end
      exp_instr = words[w];
      checks++;
      if (Retired !== exp_ret || n_il !== 1 || n_wr !== 0 || n_fl !== 0) begin
        errors++; $display("FAIL ill_totals %h retired %0d il %0d wr %0d fl %0d exp %0d 1 0 0",
                           words[w], Retired, n_il, n_wr, n_fl, exp_ret);
      end
    end
  endtask

  task automatic test_stall();
    clr_cnt();
    Load_en = 1'b0; Mem_data = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (Fsm !== 5'b00001 || Instr !== exp_instr) begin
        errors++; $display("FAIL stall cyc %0d fsm %b instr %h exp 00001 %h", i, Fsm, Instr, exp_instr);
      end
      tick();
    end
    checks++;
    if (n_pc + n_wr + n_fl + n_il + n_imm !== 0) begin
      errors++; $display("FAIL stall_strobes got %0d exp 0", n_pc + n_wr + n_fl + n_il + n_imm);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp_fsm [0:2];
    exp_fsm = '{5'b00001, 5'b00010, 5'b01000};
    clr_cnt();
    Load_en = 1'b1; Mem_data = 16'hB405;
    for (int i = 0; i < 9; i++) begin
      #1;
      checks++;
      if (Fsm !== exp_fsm[i % 3]) begin errors++; $display("FAIL b2b_fsm cyc %0d got %b exp %b", i, Fsm, exp_fsm[i % 3]); end
      tick();
    end
    Load_en = 1'b0;
    exp_ret = exp_ret + 16'd3;
    exp_instr = 16'hB405;
    #1;
    checks++;
    if (Fsm !== 5'b00001 || Retired !== exp_ret || n_pc !== 3 || n_fl !== 3 || n_wr !== 0) begin
      errors++; $display("FAIL b2b_totals fsm %b retired %0d pc %0d fl %0d wr %0d exp 00001 %0d 3 3 0",
                         Fsm, Retired, n_pc, n_fl, n_wr, exp_ret);
    end
  endtask

  task automatic test_reset_abort();
    do_reset();
    clr_cnt();
    for (int i = 0; i < 3; i++) begin
      Load_en = (i == 0); Mem_data = 16'h5405;
      #1;
      if (i < 2) tick();
    end
    checks++;
    if (Fsm !== 5'b01000) begin errors++; $display("FAIL abort_in_exec got %b exp 01000", Fsm); end
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    #1;
    checks++;
    if (Fsm !== 5'b00001 || Wr_en !== 1'b0 || Retired !== 16'h0000) begin
      errors++; $display("FAIL abort_after fsm %b wr %b retired %0d exp 00001 0 0", Fsm, Wr_en, Retired);
    end
    tick();
    checks++;
    if (n_wr !== 0 || Retired !== 16'h0000 || Fsm !== 5'b00001) begin
      errors++; $display("FAIL abort_settle wr %0d retired %0d fsm %b exp 0 0 00001", n_wr, Retired, Fsm);
    end
  endtask

  task automatic test_counter_wrap();
    rst2 = 1'b1; load_en2 = 1'b0; mem_data2 = 16'h9405;
    @(posedge Clk); #1;
    rst2 = 1'b0; load_en2 = 1'b1;
    repeat (45) begin @(posedge Clk); #1; end
    checks++;
    if (retired2 !== 4'hF) begin errors++; $display("FAIL wrap_before got %h exp f", retired2); end
    repeat (3) begin @(posedge Clk); #1; end
    checks++;
    if (retired2 !== 4'h0 || fsm2 !== 5'b00001) begin
      errors++; $display("FAIL wrap_after retired %h fsm %b exp 0 00001", retired2, fsm2);
    end
    load_en2 = 1'b0;
  endtask

  initial begin
    Rst = 1'b1; Load_en = 1'b0; Mem_data = 16'h0000;
    rst2 = 1'b1; load_en2 = 1'b0; mem_data2 = 16'h0000;
    exp_ret = 16'h0000; exp_instr = 16'h0000;
    clr_cnt();
    @(posedge Clk); #1;
    test_reset();
    test_reg_add();
    test_imm_mov();
    test_reg_cmp();
    test_illegal();
    test_stall();
    test_back_to_back();
    test_reset_abort();
    test_counter_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/double_op_ctrl.md
# double_op_ctrl

Control sequencer for the MSP430x2xx core's double-operand (format I) instructions. It fetches an instruction word, decodes opcode, register fields and addressing mode, optionally fetches an immediate extension word, then drives register-file selects, ALU operation, flag load and write-back strobes. It sits between program memory and the register-file/ALU datapath inside `MSP430x2xx` and drives the `Fsm`, `PC_inc_out`, `Wr_en_out`, `Src_reg_out` and `Dst_reg_out` observation ports.

## Interface
- `STATE_W`, 5: state vector width; states are one-hot.
- `CNT_W`, 16: width of the retired-instruction counter.
- `Clk` in 1: single clock; all state changes on its rising edge.
- `Rst` in 1: synchronous, active-high reset.
- `Load_en` in 1: run enable, sampled only in FETCH.
- `Mem_data` in 16: program-memory word at the current PC, valid every cycle.
- `Instr` out 16: latched instruction register.
- `Fsm` out `STATE_W`: current one-hot state.
- `PC_inc` out 1: one-cycle PC increment strobe.
- `Imm_ld` out 1: latch `Mem_data` as the source operand.
- `Src_sel_imm` out 1: ALU A operand comes from the immediate latch rather than the register file.
- `Src_reg` out 4: register-file read address A, from `Instr[11:8]`.
- `Dst_reg` out 4: register-file read/write address, from `Instr[3:0]`.
- `Alu_op` out 4: `Instr[15:12]`, valid in EXEC and WB.
- `Byte_op` out 1: `Instr[6]`, valid in EXEC and WB.
- `Flags_ld` out 1: SR flag-update strobe.
- `Wr_en` out 1: register-file write strobe.
- `Illegal` out 1: one-cycle pulse on an unsupported encoding.
- `Retired` out `CNT_W`: count of completed instructions.

## Operation
- One-hot states: FETCH=00001, DECODE=00010, IMM=00100, EXEC=01000, WB=10000.
- **FETCH**
  - If `Load_en`=1: `Instr`←`Mem_data`, `PC_inc`=1, go to DECODE.
  - If `Load_en`=0: hold in FETCH; no strobes; `Instr` unchanged.
- **DECODE** checks the encoding.
  - Illegal (`Illegal`=1 for one cycle, back to FETCH, `Retired` unchanged):
    - opcode `Instr[15:12]` < 4'h4;
    - `Ad`=`Instr[7]`=1;
    - `As`=`Instr[5:4]` is 01 or 10;
    - `As`=11 with src≠R0.
  - `As`=11 with src=R0 (immediate): go to IMM.
  - `As`=00: go to EXEC.
- **IMM**: `Imm_ld`=1 and `PC_inc`=1 in the same cycle; go to EXEC.
- **EXEC**
  - `Src_sel_imm` is held for EXEC and WB when the instruction was immediate.
  - `Flags_ld`=1 for every opcode except MOV (4), BIC (C) and BIS (D).
  - If the opcode writes back, go to WB. Otherwise (CMP 9, BIT B): go to FETCH and increment `Retired`.
- **WB**: `Wr_en`=1, go to FETCH, increment `Retired`.
  - `Dst_reg`=0 is a legal PC write. The datapath gives `Wr_en` priority over `PC_inc`; the controller never asserts both in one cycle.
- `Src_reg`, `Dst_reg`, `Alu_op` and `Byte_op` are combinational from `Instr` and are stable from DECODE through WB.
- `Retired` wraps from 16'hFFFF to 0 with no flag.

## Timing
- Reset values:
  - `Fsm`=00001, `Instr`=0, `Retired`=0;
  - `PC_inc`, `Imm_ld`, `Src_sel_imm`, `Flags_ld`, `Wr_en` and `Illegal` all 0;
  - `Src_reg`, `Dst_reg`, `Alu_op` and `Byte_op` are 0 because `Instr`=0.
- Latency from the FETCH cycle to re-entering FETCH:
  - register ALU op: 4 cycles;
  - register CMP/BIT: 3 cycles;
  - immediate ALU op: 5 cycles;
  - immediate CMP/BIT: 4 cycles;
  - illegal: 2 cycles.
- All strobes are registered-state decodes, high for exactly one cycle in their state.
- `PC_inc` asserts at most twice per instruction, in FETCH and IMM.
- `Rst` in any state returns to FETCH on the next edge and aborts the in-flight instruction: no `Wr_en`, no `Flags_ld`, no `Retired` increment. `Rst` has priority over `Load_en`.
- `Load_en` is ignored outside FETCH. Dropping it mid-instruction completes that instruction.

## Structure
- Package `msp430_pkg` holds:
  - opcode constants OP_MOV..OP_AND (4'h4..4'hF);
  - `As` mode constants AS_REG=00, AS_IMM=11;
  - one-hot state constants ST_FETCH..ST_WB;
  - register index constant R_PC=0.
- Sub-module `double_op_decode`: combinational decoder from `Instr` to `is_illegal`, `is_imm`, `writes_dst`, `writes_flags`.
- Top-level `double_op_ctrl` holds the state register, instruction register, counter and strobe decode.

## Test plan
- **Register ADD:** reset, `Load_en`=1, `Mem_data`=16'h5405 (ADD R4,R5).
  - `Fsm` 00001→00010→01000→10000→00001.
  - `Flags_ld` high in EXEC; `Wr_en` high in WB with `Dst_reg`=5 and `Src_reg`=4.
  - `PC_inc` pulses once; `Retired`=1.
- **Immediate MOV:** 16'h4036 (MOV #imm,R6), then 16'h1234.
  - Passes through IMM with `Imm_ld`=1 and `PC_inc`=1.
  - `Src_sel_imm`=1 in EXEC and WB; `Flags_ld`=0; `Wr_en`=1 with `Dst_reg`=6.
  - `PC_inc` total 2.
- **Register CMP:** 16'h9405.
  - EXEC then FETCH, skipping WB; `Flags_ld`=1; `Wr_en` never asserted.
  - Total 3 cycles; `Retired` increments.
- **Illegal encodings:** 16'h1004 and 16'h5415 (As=01).
  - `Illegal` pulses in DECODE; returns to FETCH; `Retired` unchanged; no `Wr_en` or `Flags_ld`.
- **Stall and reset abort:**
  - `Load_en`=0 for 3 cycles: `Fsm` stays 00001 and no strobes fire.
  - `Rst` asserted in EXEC of 16'h5405: next cycle `Fsm`=00001 with `Wr_en`=0 and `Retired` unchanged.
- **Counter wrap:** with `Retired` at 16'hFFFF (back-to-back CMPs or forced), one more retirement gives `Retired`=0.
